pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's single-cycle ripple adder.
- Adds or subtracts two C_WIDTH-bit operands with carry/borrow-in.
- The carry chain is split into C_STAGES registered segments, so width scales without limiting clock rate.
- Sits between producer/consumer blocks on a valid/ready stream and sustains one operation per cycle under no back-pressure.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/addsub_stage.sv | 100 ++++++++++
 rtl/pipelined_addsub.sv | 90 +++++++++
 tb/tb_pipelined_addsub.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared sizing helpers and defaults for the pipelined add/sub datapath.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  // Nominal segment width: ceil(width / stages).
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  // Base bit of segment k, clamped to width for trailing empty segments.
  function automatic int unsigned seg_lo(input int unsigned k, input int unsigned seg,
                                         input int unsigned width);
    return (k * seg < width) ? k * seg : width;
  endfunction

  // Bits owned by segment k; the last populated segment takes the remainder.
  function automatic int unsigned seg_len(input int unsigned k, input int unsigned seg,
                                          input int unsigned width);
    int unsigned lo;
    lo = seg_lo(k, seg, width);
    return (width - lo < seg) ? width - lo : seg;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One carry-chain segment of pipelined_addsub with its payload/valid register.
// Carries the signed-overflow flag when PIPELINED_ADDSUB_OVF_EN is defined.
module addsub_stage
  import adder_pkg::*;
#(
  parameter int unsigned C_WIDTH = DEF_WIDTH,
  parameter int unsigned LO      = 0,
  parameter int unsigned W       = 1,
  parameter bit          LAST    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               load_c,
  input  logic               adv,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic [C_WIDTH-1:0] res,
  input  logic               cin,
  input  logic               sub,
`ifdef PIPELINED_ADDSUB_OVF_EN
  input  logic               ovf,
  output logic               ovf_q,
`endif
  output logic               out_valid,
  output logic [C_WIDTH-1:0] a_q,
  output logic [C_WIDTH-1:0] b_q,
  output logic [C_WIDTH-1:0] res_q,
  output logic               co_q,
  output logic               sub_q
);

  logic               c_nxt;
  logic               co_d;
  logic [C_WIDTH-1:0] res_d;
`ifdef PIPELINED_ADDSUB_OVF_EN
  logic               ovf_d;
`endif

  if (W == 0) begin : g_pass
    assign res_d = res;
    assign c_nxt = cin;
`ifdef PIPELINED_ADDSUB_OVF_EN
    assign ovf_d = ovf;
`endif
  end else begin : g_seg
    localparam int unsigned SW = W + 1;
    logic [W:0] sum;

    assign sum = SW'(a[LO +: W]) + SW'(b[LO +: W]) + SW'(cin);

    always_comb begin
      res_d           = res;
      res_d[LO +: W]  = sum[W-1:0];
    end

    assign c_nxt = sum[W];

`ifdef PIPELINED_ADDSUB_OVF_EN
    if (LO + W == C_WIDTH) begin : g_msb
      localparam int unsigned MSB = C_WIDTH - 1;
      // Carry into MSB differs from carry out; upstream flag is always clear here.
      assign ovf_d = ovf | (a[MSB] ^ b[MSB] ^ sum[W-1] ^ sum[W]);
    end else begin : g_mid
      assign ovf_d = ovf;
    end
`endif
  end

  // The final stage turns the internal carry into a borrow for subtraction.
  assign co_d   = LAST ? (c_nxt ^ sub) : c_nxt;
  assign load_c = !out_valid || adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      co_q      <= 1'b0;
      sub_q     <= 1'b0;
`ifdef PIPELINED_ADDSUB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else if (load_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        res_q <= res_d;
        co_q  <= co_d;
        sub_q <= sub;
`ifdef PIPELINED_ADDSUB_OVF_EN
        ovf_q <= ovf_d;
`endif
      end
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with carry/borrow-in on a valid/ready stream.
// Optional signed-overflow output enabled by PIPELINED_ADDSUB_OVF_EN.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int unsigned C_WIDTH  = DEF_WIDTH,
  parameter int unsigned C_STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               sub,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH:0]   y
`ifdef PIPELINED_ADDSUB_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int unsigned SEG = seg_width(C_WIDTH, C_STAGES);

  // Index k is the input of stage k; index C_STAGES is the pipeline output.
  logic               vld [C_STAGES+1];
  logic               ld  [C_STAGES+1];
  logic [C_WIDTH-1:0] opa [C_STAGES+1];
  logic [C_WIDTH-1:0] opb [C_STAGES+1];
  logic [C_WIDTH-1:0] res [C_STAGES+1];
  logic               cy  [C_STAGES+1];
  logic               sb  [C_STAGES+1];
`ifdef PIPELINED_ADDSUB_OVF_EN
  logic               ov  [C_STAGES+1];
`endif

  // Subtraction is a + ~b + ~cin through the same adder.
  assign vld[0] = in_valid;
  assign opa[0] = a;
  assign opb[0] = sub ? ~b : b;
  assign res[0] = '0;
  assign cy[0]  = cin ^ sub;
  assign sb[0]  = sub;
`ifdef PIPELINED_ADDSUB_OVF_EN
  assign ov[0]  = 1'b0;
`endif

  assign ld[C_STAGES] = out_ready;
  assign in_ready     = ld[0];

  for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
    addsub_stage #(
      .C_WIDTH (C_WIDTH),
      .LO      (seg_lo(k, SEG, C_WIDTH)),
      .W       (seg_len(k, SEG, C_WIDTH)),
      .LAST    (k == C_STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[k]),
      .load_c    (ld[k]),
      .adv       (ld[k+1]),
      .a         (opa[k]),
      .b         (opb[k]),
      .res       (res[k]),
      .cin       (cy[k]),
      .sub       (sb[k]),
`ifdef PIPELINED_ADDSUB_OVF_EN
      .ovf       (ov[k]),
      .ovf_q     (ov[k+1]),
`endif
      .out_valid (vld[k+1]),
      .a_q       (opa[k+1]),
      .b_q       (opb[k+1]),
      .res_q     (res[k+1]),
      .co_q      (cy[k+1]),
      .sub_q     (sb[k+1])
    );
  end

  assign out_valid = vld[C_STAGES];
  assign y         = {cy[C_STAGES], res[C_STAGES]};
`ifdef PIPELINED_ADDSUB_OVF_EN
  assign ovf       = ov[C_STAGES];
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub against an arithmetic reference queue.
module tb_pipelined_addsub;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 4;
  localparam int unsigned W1 = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   y;
`ifdef PIPELINED_ADDSUB_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W:0] y;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         strict = 1'b1;
  bit         stalled_prev = 1'b0;
  bit         got_out = 1'b0;
  logic [W:0] y_prev = '0;
  logic [W:0] last_y = '0;
  logic       last_ovf = 1'b0;

  always #5 clk = ~clk;

  pipelined_addsub #(.C_WIDTH(W), .C_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Plain-arithmetic reference for one beat.
  function automatic exp_t model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                 input logic rsub, input logic rcin);
    exp_t e;
    longint unsigned ua, ub, uc;
    logic r;
    ua = 64'(ra);
    ub = 64'(rb);
    uc = 64'(rcin);
    if (!rsub) begin
      e.y = W1'(ua + ub + uc);
    end else begin
      e.y[W-1:0] = W'(ua - ub - uc);
      e.y[W]     = (ua < ub + uc);
    end
    r = e.y[W-1];
    if (!rsub) e.ovf = (ra[W-1] == rb[W-1]) && (r != ra[W-1]);
    else       e.ovf = (ra[W-1] != rb[W-1]) && (r != ra[W-1]);
    e.cyc = cyc;
    return e;
  endfunction

  // One clock: drive on the falling edge, sample 1ns later, account for the next rising edge.
  task automatic step(input logic iv, input logic ordy, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input logic isub, input logic icin);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    a         = ia;
    b         = ib;
    sub       = isub;
    cin       = icin;
    #1;
    got_out = 1'b0;
    if (stalled_prev) begin
      chk("hold_valid", W1'(out_valid), W1'(1));
      chk("hold_y", y, y_prev);
    end
    chk("in_ready", W1'(in_ready), W1'((q.size() < S) || ordy));
    if (out_valid && out_ready) begin
      chk("no_spurious_out", W1'(q.size() != 0), W1'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("y", y, e.y);
`ifdef PIPELINED_ADDSUB_OVF_EN
        chk("ovf", W1'(ovf), W1'(e.ovf));
        last_ovf = ovf;
`endif
        if (strict) chk("latency", W1'(cyc - e.cyc), W1'(S));
        last_y  = y;
        got_out = 1'b1;
      end
    end
    if (in_valid && in_ready) q.push_back(model(ia, ib, isub, icin));
    stalled_prev = out_valid && !out_ready;
    y_prev       = y;
    cyc++;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin, input logic [W:0] expv);
    int n;
    n = 0;
    step(1'b1, 1'b1, ia, ib, isub, icin);
    do begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      n++;
    end while (!got_out && n < 10);
    chk({tag, "_timeout"}, W1'(got_out), W1'(1));
    if (got_out) chk(tag, last_y, expv);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      n++;
    end
    chk("drained", W1'(q.size()), W1'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #1;
    chk("reset_out_valid", W1'(out_valid), W1'(0));
    chk("reset_in_ready", W1'(in_ready), W1'(1));
    chk("reset_y", y, W1'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    strict = 1'b1;
    run_one("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000);
    run_one("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 33'h1_FFFF_FFFD);
    run_one("sub_plain", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 33'h0_0000_0002);
    run_one("add_all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 33'h1_FFFF_FFFF);
`ifdef PIPELINED_ADDSUB_OVF_EN
    run_one("ovf_add_y", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000);
    chk("ovf_add", W1'(last_ovf), W1'(1));
    run_one("ovf_sub_y", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 33'h0_7FFF_FFFF);
    chk("ovf_sub", W1'(last_ovf), W1'(1));
    run_one("ovf_none_y", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0002);
    chk("ovf_none", W1'(last_ovf), W1'(0));
`endif

    // Back-to-back stream, no back-pressure.
    for (int i = 0; i < 100; i++)
      step(1'b1, 1'b1, W'($urandom()), W'($urandom()), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)));
    drain();

    // Random back-pressure under continuous input.
    strict = 1'b0;
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom_range(1, 0)), W'($urandom()), W'($urandom()),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    drain();

    // Reset with three beats in flight.
    strict = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, W'($urandom()), W'($urandom()), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", W1'(out_valid), W1'(0));
    chk("midrst_in_ready", W1'(in_ready), W1'(1));
    chk("midrst_y", y, W1'(0));
    q.delete();
    stalled_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    run_one("post_reset", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 33'h0_0000_0003);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
